ccr_shadow_stack: RTL and testbench



---
 rtl/ccr_shadow_stack.sv | 150 +++++++++++++++
 tb/tb_ccr_shadow_stack.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccr_shadow_stack.sv
// ccr_shadow_stack
//   Condition code register with per-bit masked ALU update, SETC/CLRC carry
//   control and a DEPTH-entry shadow stack for nested interrupt save/restore.
//   Sits beside the ALU in the execute stage.
//
//   Optional feature (macro CCR_FWD_EN): adds flags_fwd, a combinational copy
//   of the flag register's next-state value, forced to RST_FLAGS during rst.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   alu_we       enable masked ALU flag update
//   alu_mask     per-bit update mask for alu_flags
//   alu_flags    flags produced by the ALU
//   set_carry    SETC (wins over clear_carry)
//   clear_carry  CLRC
//   int_save     push current flags onto the shadow stack
//   rti_restore  pop the shadow stack into the flags
//   clr_err      clear sticky error bits (a same-cycle error wins)
//   flags_out    registered flags
//   flags_fwd    next-state flags (CCR_FWD_EN builds only)
//   depth_out    number of valid stack entries
//   stack_full   depth_out == DEPTH
//   stack_empty  depth_out == 0
//   ovf_err      sticky: save attempted while full
//   unf_err      sticky: restore attempted while empty
module ccr_shadow_stack #(
    parameter int                FLAG_W    = 4,
    parameter int                DEPTH     = 4,
    parameter int                C_BIT     = 2,
    parameter logic [FLAG_W-1:0] RST_FLAGS = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_we,
    input  logic [FLAG_W-1:0]            alu_mask,
    input  logic [FLAG_W-1:0]            alu_flags,
    input  logic                         set_carry,
    input  logic                         clear_carry,
    input  logic                         int_save,
    input  logic                         rti_restore,
    input  logic                         clr_err,
    output logic [FLAG_W-1:0]            flags_out,
`ifdef CCR_FWD_EN
    output logic [FLAG_W-1:0]            flags_fwd,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   depth_out,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int DW = $clog2(DEPTH+1);
    // Stack index width; a one-entry stack still needs a 1-bit index.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

    logic [FLAG_W-1:0] stack [DEPTH];

    logic [FLAG_W-1:0] flags_nxt;
    logic [DW-1:0]     depth_nxt;
    logic [IW-1:0]     push_idx;
    logic [IW-1:0]     top_idx;
    logic              do_pop;
    logic              do_swap;
    logic              do_push;
    logic              ovf_set;
    logic              unf_set;

    assign push_idx = depth_out[IW-1:0];
    assign top_idx  = IW'(depth_out - DW'(1));

    // A restore on an empty stack only counts as an underflow when it is not
    // paired with a save; the pair then degrades to a plain save.
    assign do_pop  = rti_restore && !stack_empty;
    assign do_swap = do_pop && int_save;
    assign do_push = int_save && !stack_full && !do_pop;
    assign ovf_set = int_save && stack_full && !rti_restore;
    assign unf_set = rti_restore && stack_empty && !int_save;

    always_comb begin
        flags_nxt = flags_out;
        if (do_pop) begin
            flags_nxt = stack[top_idx];
        end else if (unf_set) begin
            // Failed restore freezes the flags; ALU/SETC/CLRC are dropped.
            flags_nxt = flags_out;
        end else if (set_carry) begin
            flags_nxt[C_BIT] = 1'b1;
        end else if (clear_carry) begin
            flags_nxt[C_BIT] = 1'b0;
        end else if (alu_we) begin
            flags_nxt = (flags_out & ~alu_mask) | (alu_flags & alu_mask);
        end
    end

    always_comb begin
        depth_nxt = depth_out;
        if (do_push) begin
            depth_nxt = depth_out + DW'(1);
        end else if (do_pop && !do_swap) begin
            depth_nxt = depth_out - DW'(1);
        end
    end

`ifdef CCR_FWD_EN
    assign flags_fwd = rst ? RST_FLAGS : flags_nxt;
`endif

    // Control and flag state
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_out   <= RST_FLAGS;
            depth_out   <= '0;
            stack_full  <= 1'b0;
            stack_empty <= 1'b1;
            ovf_err     <= 1'b0;
            unf_err     <= 1'b0;
        end else begin
            flags_out   <= flags_nxt;
            depth_out   <= depth_nxt;
            stack_full  <= (depth_nxt == DEPTH_V);
            stack_empty <= (depth_nxt == '0);
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end else if (clr_err) begin
                ovf_err <= 1'b0;
            end
            if (unf_set) begin
                unf_err <= 1'b1;
            end else if (clr_err) begin
                unf_err <= 1'b0;
            end
        end
    end

    // Stack storage: not reset, entries above depth_out are meaningless.
    // Both push and swap store the pre-update flag value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_push) begin
                stack[push_idx] <= flags_out;
            end else if (do_swap) begin
                stack[top_idx] <= flags_out;
            end
        end
    end

endmodule

// File: tb/tb_ccr_shadow_stack.sv
module tb_ccr_shadow_stack;

    localparam int FLAG_W = 4;
    localparam int DEPTH  = 4;
    localparam int C_BIT  = 2;
    localparam logic [3:0] RSTF = 4'h0;

    logic       clk;
    logic       rst;
    logic       alu_we;
    logic [3:0] alu_mask;
    logic [3:0] alu_flags;
    logic       set_carry;
    logic       clear_carry;
    logic       int_save;
    logic       rti_restore;
    logic       clr_err;
    logic [3:0] flags_out;
`ifdef CCR_FWD_EN
    logic [3:0] flags_fwd;
`endif
    logic [2:0] depth_out;
    logic       stack_full;
    logic       stack_empty;
    logic       ovf_err;
    logic       unf_err;

    int total = 0;
    int bad   = 0;

    ccr_shadow_stack #(
        .FLAG_W(FLAG_W), .DEPTH(DEPTH), .C_BIT(C_BIT), .RST_FLAGS(RSTF)
    ) dut (
        .clk(clk), .rst(rst), .alu_we(alu_we), .alu_mask(alu_mask),
        .alu_flags(alu_flags), .set_carry(set_carry), .clear_carry(clear_carry),
        .int_save(int_save), .rti_restore(rti_restore), .clr_err(clr_err),
        .flags_out(flags_out),
`ifdef CCR_FWD_EN
        .flags_fwd(flags_fwd),
`endif
        .depth_out(depth_out), .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: flags plus a LIFO queue ----------------
    logic [3:0] m_flags;
    logic [3:0] m_stk[$];
    logic       m_ovf;
    logic       m_unf;
    bit         m_valid = 0;

    always @(posedge clk) begin : model
        logic [3:0] old;
        logic [3:0] nf;
        bit         o_s;
        bit         u_s;
        if (rst) begin
            m_flags = RSTF;
            m_stk.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1;
        end else if (m_valid) begin
            old = m_flags;
            o_s = 0;
            u_s = 0;
            if (rti_restore && m_stk.size() > 0) begin
                m_flags = m_stk[$];
                if (int_save) m_stk[m_stk.size()-1] = old;
                else          void'(m_stk.pop_back());
            end else if (rti_restore && !int_save) begin
                u_s = 1;
            end else begin
                nf = old;
                if (set_carry)        nf[C_BIT] = 1'b1;
                else if (clear_carry) nf[C_BIT] = 1'b0;
                else if (alu_we)      nf = (old & ~alu_mask) | (alu_flags & alu_mask);
                m_flags = nf;
                if (int_save) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(old);
                    else                      o_s = 1;
                end
            end
            m_ovf = o_s ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
            m_unf = u_s ? 1'b1 : (clr_err ? 1'b0 : m_unf);
        end
    end

    // Compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_valid) begin
            chk("flags",  32'(flags_out),   32'(m_flags));
            chk("depth",  32'(depth_out),   32'(m_stk.size()));
            chk("full",   32'(stack_full),  32'(m_stk.size() == DEPTH));
            chk("empty",  32'(stack_empty), 32'(m_stk.size() == 0));
            chk("ovf",    32'(ovf_err),     32'(m_ovf));
            chk("unf",    32'(unf_err),     32'(m_unf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic we, input logic [3:0] mk,
                         input logic [3:0] af, input logic sc, input logic cc,
                         input logic sv, input logic rt, input logic ce);
        @(negedge clk);
        rst = r; alu_we = we; alu_mask = mk; alu_flags = af;
        set_carry = sc; clear_carry = cc; int_save = sv; rti_restore = rt; clr_err = ce;
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    // One driven cycle followed by an idle; returns when its result is visible.
    task automatic step(input logic r, input logic we, input logic [3:0] mk,
                        input logic [3:0] af, input logic sc, input logic cc,
                        input logic sv, input logic rt, input logic ce);
        drive(r, we, mk, af, sc, cc, sv, rt, ce);
        idle();
    endtask

    task automatic alu(input logic [3:0] v);
        step(0, 1, 4'hF, v, 0, 0, 0, 0, 0);
    endtask

    task automatic save();
        step(0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 0);
    endtask

    task automatic restore();
        step(0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 0; alu_we = 0; alu_mask = 0; alu_flags = 0;
        set_carry = 0; clear_carry = 0; int_save = 0; rti_restore = 0; clr_err = 0;

        // Reset overrides a same-cycle ALU write
        step(1, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0);
        chk("rst_flags", 32'(flags_out), 32'h0);
        chk("rst_depth", 32'(depth_out), 32'h0);
        chk("rst_empty", 32'(stack_empty), 32'h1);
        chk("rst_full",  32'(stack_full), 32'h0);
        chk("rst_ovf",   32'(ovf_err), 32'h0);
        chk("rst_unf",   32'(unf_err), 32'h0);

        // Masked update, then SETC+CLRC together beating an ALU write
        alu(4'b0101);
        step(0, 1, 4'b0011, 4'b1010, 0, 0, 0, 0, 0);
        chk("mask_upd", 32'(flags_out), 32'b0110);
        step(0, 1, 4'hF, 4'h0, 1, 1, 0, 0, 0);
        chk("setc_clrc", 32'(flags_out), 32'b0110);
        step(0, 0, 4'h0, 4'h0, 0, 1, 0, 0, 0);
        chk("clrc", 32'(flags_out), 32'b0010);
        step(0, 1, 4'h0, 4'hF, 0, 0, 0, 0, 0);
        chk("mask_zero", 32'(flags_out), 32'b0010);

        // Nested save/restore, LIFO order
        alu(4'h1); save();
        alu(4'h2); save();
        alu(4'h3); save();
        chk("nest_depth", 32'(depth_out), 32'd3);
        alu(4'h7);
        restore(); chk("lifo_3", 32'(flags_out), 32'h3);
        restore(); chk("lifo_2", 32'(flags_out), 32'h2);
        restore(); chk("lifo_1", 32'(flags_out), 32'h1);
        chk("lifo_empty", 32'(stack_empty), 32'h1);

        // Overflow: five saves, each with an ALU write in the same cycle
        for (int i = 0; i < 5; i++) step(0, 1, 4'hF, 4'(8 + i), 0, 0, 1, 0, 0);
        chk("ovf_depth", 32'(depth_out), 32'd4);
        chk("ovf_full",  32'(stack_full), 32'h1);
        chk("ovf_err",   32'(ovf_err), 32'h1);
        chk("ovf_flags", 32'(flags_out), 32'hC);
        step(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 1);
        chk("ovf_clr", 32'(ovf_err), 32'h0);
        restore(); chk("ovf_top", 32'(flags_out), 32'hA);
        restore(); restore(); restore();
        chk("ovf_bottom", 32'(flags_out), 32'h1);

        // Underflow freezes flags despite ALU write; error beats clear
        step(0, 1, 4'hF, 4'hF, 0, 0, 0, 1, 0);
        chk("unf_flags", 32'(flags_out), 32'h1);
        chk("unf_err",   32'(unf_err), 32'h1);
        chk("unf_depth", 32'(depth_out), 32'h0);
        step(0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 1);
        chk("unf_setwins", 32'(unf_err), 32'h1);
        step(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 1);
        chk("unf_clr", 32'(unf_err), 32'h0);

        // Swap with one entry
        alu(4'h9); save(); alu(4'h4);
        drive(0, 0, 4'h0, 4'h0, 0, 0, 1, 1, 0);
`ifdef CCR_FWD_EN
        #1 chk("swap_fwd", 32'(flags_fwd), 32'h9);
`endif
        idle();
        chk("swap_flags", 32'(flags_out), 32'h9);
        chk("swap_depth", 32'(depth_out), 32'd1);
        restore();
        chk("swap_back", 32'(flags_out), 32'h4);

        // Swap on empty stack acts as a plain save, no underflow
        step(0, 1, 4'hF, 4'h6, 0, 0, 1, 1, 0);
        chk("swape_flags", 32'(flags_out), 32'h6);
        chk("swape_depth", 32'(depth_out), 32'd1);
        chk("swape_unf",   32'(unf_err), 32'h0);

        // Reset mid-operation discards saved entries
        save();
        step(1, 0, 4'h0, 4'h0, 0, 0, 1, 0, 0);
        chk("midrst_depth", 32'(depth_out), 32'h0);
        chk("midrst_flags", 32'(flags_out), 32'h0);

        // Back-to-back pseudo-random traffic, checked by the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 79) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0));
        end
        idle();
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
